// File: rtl/nn_pkg.sv
// Shared widths and FSM encoding for the processing-element sequencer slice.
package nn_pkg;
  localparam int NN_ADDR_WIDTH = 3;
  localparam int NN_DATA_WIDTH = 16;
  localparam int NN_PSUM_WIDTH = 2*NN_DATA_WIDTH + NN_ADDR_WIDTH;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MAC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;
endpackage

// File: rtl/pe_mac.sv
// Signed multiply-accumulate: full-width product, sign-extended into a wrapping accumulator.
// Priority is clear > load > enable; one accumulate per enabled cycle.
module pe_mac
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH = NN_DATA_WIDTH,
  parameter int PSUM_WIDTH = NN_PSUM_WIDTH
) (
  input  logic                         clk,
  input  logic                         clr,
  input  logic                         load,
  input  logic signed [PSUM_WIDTH-1:0] load_val,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [PSUM_WIDTH-1:0] acc
);
  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [PSUM_WIDTH-1:0]   prod_ext;

  always_comb begin
    prod     = a * b;
    prod_ext = PSUM_WIDTH'(prod);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      acc <= '0;
    end else if (load) begin
      acc <= load_val;
    end else if (en) begin
      acc <= acc + prod_ext;
    end
  end
endmodule

// File: rtl/pe_mac_sequencer.sv
// Walks k over the scratchpads for a latched tap count, then holds the result until accepted.
// Result appears taps+1 cycles after start; held stable while psum_ready is low.
module pe_mac_sequencer
  import nn_pkg::*;
#(
  parameter int ADDR_WIDTH = NN_ADDR_WIDTH,
  parameter int DATA_WIDTH = NN_DATA_WIDTH,
  parameter int DEPTH      = 2**ADDR_WIDTH,
  parameter int PSUM_WIDTH = 2*DATA_WIDTH + ADDR_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [ADDR_WIDTH:0]          num_taps,
  input  logic signed [PSUM_WIDTH-1:0] psum_in,
  output logic [ADDR_WIDTH-1:0]        filt_select,
  output logic [ADDR_WIDTH-1:0]        ifmap_select,
  input  logic signed [DATA_WIDTH-1:0] filt_value,
  input  logic signed [DATA_WIDTH-1:0] ifmap_value,
  output logic signed [PSUM_WIDTH-1:0] psum_out,
  output logic                         psum_valid,
  input  logic                         psum_ready,
  output logic                         ifmap_shift,
  output logic                         busy
);
  localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] ONE     = (ADDR_WIDTH+1)'(1);

  logic [1:0]            state;
  logic [ADDR_WIDTH:0]   k;
  logic [ADDR_WIDTH:0]   taps;
  logic [ADDR_WIDTH:0]   taps_clamped;
  logic [ADDR_WIDTH:0]   k_next;
  logic                  accept;

  always_comb begin
    taps_clamped = (num_taps > DEPTH_W) ? DEPTH_W : num_taps;
    k_next       = k + ONE;
    accept       = (state == ST_IDLE) && start;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      k     <= '0;
      taps  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            taps  <= taps_clamped;
            k     <= '0;
            state <= (taps_clamped == '0) ? ST_DONE : ST_MAC;
          end
        end
        ST_MAC: begin
          k <= k_next;
          if (k_next == taps) state <= ST_DONE;
        end
        ST_DONE: begin
          if (psum_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pe_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .PSUM_WIDTH(PSUM_WIDTH)
  ) u_mac (
    .clk      (clk),
    .clr      (rst),
    .load     (accept),
    .load_val (psum_in),
    .en       (state == ST_MAC),
    .a        (filt_value),
    .b        (ifmap_value),
    .acc      (psum_out)
  );

  // Gating with rst keeps an aborted DONE from sliding the ifmap window.
  always_comb begin
    filt_select  = (state == ST_MAC) ? k[ADDR_WIDTH-1:0] : '0;
    ifmap_select = filt_select;
    psum_valid   = (state == ST_DONE);
    ifmap_shift  = (state == ST_DONE) && psum_ready && !rst;
    busy         = (state != ST_IDLE);
  end
endmodule

// File: tb/tb_pe_mac_sequencer.sv
// Directed scenarios with an expected-result queue drained by an independent output monitor.
module tb_pe_mac_sequencer;
  localparam int AW = 3;
  localparam int DW = 16;
  localparam int PW = 2*DW + AW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [AW:0]          num_taps;
  logic signed [PW-1:0] psum_in;
  logic [AW-1:0]        filt_select;
  logic [AW-1:0]        ifmap_select;
  logic signed [DW-1:0] filt_value;
  logic signed [DW-1:0] ifmap_value;
  logic signed [PW-1:0] psum_out;
  logic                 psum_valid;
  logic                 psum_ready;
  logic                 ifmap_shift;
  logic                 busy;

  logic signed [DW-1:0] filt_mem  [8];
  logic signed [DW-1:0] ifmap_mem [8];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int shift_count = 0;
  int sc;
  int n;
  logic signed [PW-1:0] exp_q [$];
  logic signed [PW-1:0] e;
  int xfer_cyc [$];

  pe_mac_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .num_taps     (num_taps),
    .psum_in      (psum_in),
    .filt_select  (filt_select),
    .ifmap_select (ifmap_select),
    .filt_value   (filt_value),
    .ifmap_value  (ifmap_value),
    .psum_out     (psum_out),
    .psum_valid   (psum_valid),
    .psum_ready   (psum_ready),
    .ifmap_shift  (ifmap_shift),
    .busy         (busy)
  );

  assign filt_value  = filt_mem[filt_select];
  assign ifmap_value = ifmap_mem[ifmap_select];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // Monitor: every accepted result is popped and compared.
  always @(negedge clk) begin
    if (ifmap_shift) shift_count++;
    if (!rst && psum_valid && psum_ready) begin
      xfer_cyc.push_back(cyc);
      check("shift_on_xfer", ifmap_shift, 1);
      check("sel_outside_mac", filt_select, 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_result: got %0d expected none", psum_out);
      end else begin
        e = exp_q.pop_front();
        check("psum_out", psum_out, e);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int taps, input logic signed [PW-1:0] seed);
    start    = 1'b1;
    num_taps = taps[AW:0];
    psum_in  = seed;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int exp_lat, input int n0);
    int k = n0;
    while (!psum_valid && k < 64) begin
      tick();
      k++;
    end
    check(name, k, exp_lat);
  endtask

  task automatic wait_idle;
    int k = 0;
    while (busy && k < 64) begin
      tick();
      k++;
    end
    check("idle_reached", busy, 0);
  endtask

  task automatic load_s1;
    for (int i = 0; i < 8; i++) begin
      filt_mem[i]  = (i < 4) ? DW'(i + 1) : '0;
      ifmap_mem[i] = (i < 4) ? DW'(i + 5) : '0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; psum_ready = 1'b1; num_taps = '0; psum_in = '0;
    load_s1();
    repeat (3) tick();
    check("rst_psum_out", psum_out, 0);
    check("rst_valid", psum_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_shift", ifmap_shift, 0);
    check("rst_filt_sel", filt_select, 0);
    rst = 1'b0;
    tick();

    // Basic 4-tap dot product: 10 + 5 + 12 + 21 + 32 = 80
    exp_q.push_back(80);
    issue(4, 10);
    check("busy_in_mac", busy, 1);
    check("sel_k0", filt_select, 0);
    tick();
    check("sel_k1", ifmap_select, 1);
    wait_valid("lat_4taps", 5, 2);
    wait_idle();

    // Zero taps: seed passes straight through
    exp_q.push_back(-7);
    issue(0, -7);
    wait_valid("lat_0taps", 1, 1);
    check("zero_filt_sel", filt_select, 0);
    check("zero_ifmap_sel", ifmap_select, 0);
    wait_idle();

    // Clamp 15 -> 8 taps, each product 2^30, sum 2^33 without wrap
    for (int i = 0; i < 8; i++) begin
      filt_mem[i]  = -16'sd32768;
      ifmap_mem[i] = -16'sd32768;
    end
    exp_q.push_back(64'sd8589934592);
    issue(15, 0);
    wait_valid("lat_clamped", 9, 1);
    wait_idle();

    // Backpressure: hold ready low with start pulses, then accept
    load_s1();
    psum_ready = 1'b0;
    exp_q.push_back(170);
    issue(4, 100);
    wait_valid("lat_bp", 5, 1);
    sc = shift_count;
    for (int i = 0; i < 6; i++) begin
      start = 1'b1;
      tick();
      check("bp_hold_out", psum_out, 170);
      check("bp_hold_valid", psum_valid, 1);
      check("bp_no_shift", ifmap_shift, 0);
    end
    psum_ready = 1'b1;
    #1;
    check("bp_shift_now", ifmap_shift, 1);
    tick();
    start = 1'b0;
    check("bp_start_ignored", busy, 0);
    check("bp_one_shift", shift_count - sc, 1);
    tick();
    check("bp_no_extra_shift", shift_count - sc, 1);

    // Reset on the second MAC cycle
    sc = shift_count;
    issue(4, 10);
    tick();
    rst = 1'b1;
    tick();
    check("abort_psum_out", psum_out, 0);
    check("abort_valid", psum_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_sel", filt_select, 0);
    check("abort_shift", ifmap_shift, 0);
    rst = 1'b0;
    // Reset while a result waits, with ready rising in the same cycle
    psum_ready = 1'b0;
    issue(0, 55);
    wait_valid("lat_pending", 1, 1);
    rst = 1'b1;
    psum_ready = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_done_valid", psum_valid, 0);
    check("abort_no_shift", shift_count - sc, 0);
    exp_q.push_back(67);
    issue(4, -3);
    wait_valid("lat_after_rst", 5, 1);
    wait_idle();

    // Back-to-back with start held high: 1 + 5 + 12 = 18 each, period 4
    xfer_cyc.delete();
    sc = shift_count;
    repeat (3) exp_q.push_back(18);
    start = 1'b1; num_taps = 2; psum_in = 1;
    n = 0;
    while (shift_count < sc + 3 && n < 100) begin
      tick();
      n++;
      if (ifmap_shift && shift_count == sc + 2) start = 1'b0;
    end
    start = 1'b0;
    check("b2b_count", shift_count - sc, 3);
    if (xfer_cyc.size() >= 3) begin
      check("b2b_gap1", xfer_cyc[1] - xfer_cyc[0], 4);
      check("b2b_gap2", xfer_cyc[2] - xfer_cyc[1], 4);
    end else begin
      check("b2b_xfers", xfer_cyc.size(), 3);
    end
    tick();
    check("b2b_idle_after", busy, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pe_mac_sequencer.md
PE_MAC_SEQUENCER -- requirements
Module: pe_mac_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 3, scratchpad address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, signed scratchpad element width.
REQ-003 SHALL have parameter DEPTH, default 2**ADDR_WIDTH, scratchpad element count.
REQ-004 SHALL have parameter PSUM_WIDTH, default 2*DATA_WIDTH+ADDR_WIDTH, signed partial-sum width.
REQ-005 SHALL have port clk, input, 1, sole clock; all state changes on rising edge.
REQ-006 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-007 SHALL have port start, input, 1, request one dot product; sampled only in IDLE.
REQ-008 SHALL have port num_taps, input, ADDR_WIDTH+1, tap count; sampled with start.
REQ-009 SHALL have port psum_in, input signed, PSUM_WIDTH, accumulator seed; sampled with start.
REQ-010 SHALL have port filt_select, output, ADDR_WIDTH, read select to the filter scratchpad.
REQ-011 SHALL have port ifmap_select, output, ADDR_WIDTH, read select to the ifmap scratchpad.
REQ-012 SHALL have port filt_value, input signed, DATA_WIDTH, combinational filter scratchpad read data.
REQ-013 SHALL have port ifmap_value, input signed, DATA_WIDTH, combinational ifmap scratchpad read data.
REQ-014 SHALL have port psum_out, output signed, PSUM_WIDTH, result data.
REQ-015 SHALL have port psum_valid, output, 1, psum_out holds a valid result.
REQ-016 SHALL have port psum_ready, input, 1, consumer accepts the result.
REQ-017 SHALL have port ifmap_shift, output, 1, one-cycle load_enable pulse to the ifmap scratchpad (slide the window).
REQ-018 SHALL have port busy, output, 1, high in any state other than IDLE.

Function
REQ-019 SHALL implement an FSM with states IDLE, MAC and DONE.
REQ-020 IDLE with start=1 SHALL latch num_taps and psum_in into acc, clear tap counter k, and go to MAC; if num_taps=0, it SHALL go directly to DONE.
REQ-021 num_taps greater than DEPTH SHALL be clamped to DEPTH at latch time.
REQ-022 In MAC, filt_select and ifmap_select SHALL both equal k, and each cycle SHALL perform acc <= acc + sign-extended(filt_value*ifmap_value), with a full 2*DATA_WIDTH signed product.
REQ-023 MAC SHALL last exactly the latched tap count cycles, then go to DONE; a start sampled at edge T SHALL give psum_valid=1 from cycle T+1+taps.
REQ-024 Accumulation SHALL be two's-complement and wrap at PSUM_WIDTH without saturation.
REQ-025 In DONE, psum_valid SHALL be 1 and psum_out SHALL equal acc, held stable until psum_ready=1.
REQ-026 When psum_valid and psum_ready are both 1, the transfer SHALL complete on that edge, with ifmap_shift=1 for exactly that cycle and return to IDLE.
REQ-027 start SHALL be ignored outside IDLE, and a start coincident with a transfer SHALL be ignored (next start is accepted one cycle later).
REQ-028 Outside MAC, the select outputs SHALL be 0.
REQ-029 psum_ready SHALL be ignored outside DONE.

Reset
REQ-030 rst=1 at an edge SHALL force IDLE, clear acc and k, and drive psum_out=0, psum_valid=0, ifmap_shift=0, busy=0 and both selects=0.
REQ-031 rst SHALL abort any in-progress MAC or pending DONE result without emitting ifmap_shift.

Structure
REQ-032 A shared package nn_pkg SHALL hold ADDR_WIDTH, DATA_WIDTH and PSUM_WIDTH defaults plus the FSM state encoding.
REQ-033 The multiply-accumulate datapath SHALL be one sub-module, pe_mac (product, sign extension, accumulate register with clear/load/enable).
REQ-034 The FSM and tap counter SHALL reside in pe_mac_sequencer.

Verification
REQ-035 Scenario: filt = {1,2,3,4,0,0,0,0}, ifmap = {5,6,7,8,...}, num_taps=4, psum_in=10 -> psum_out=80, psum_valid rises 5 cycles after start.
REQ-036 Scenario: num_taps=0, psum_in=-7 -> psum_valid next cycle with psum_out=-7, no select activity.
REQ-037 Scenario: num_taps=15 (DEPTH=8), all elements -32768 -> clamped to 8 taps, psum_out=8*2^30 with no wrap.
REQ-038 Scenario: psum_ready held 0 for 6 cycles -> psum_out and psum_valid stable; start pulses ignored; single ifmap_shift pulse on the accepting edge.
REQ-039 Scenario: rst asserted on the 2nd MAC cycle -> next cycle all outputs 0, IDLE, no ifmap_shift; a following start computes correctly from the new psum_in.
REQ-040 Scenario: start held high continuously with psum_ready=1 -> back-to-back results, one IDLE cycle between transfer and the next MAC.
